// File: rtl/pool_relu_q.sv
// ReLU + requantize (16b -> 7b magnitude) + 2x2 stride-2 max pool over a pixel stream.
// Horizontal maxima of even rows live in a half-width line buffer; outputs are registered, 1 cycle after the completing pixel.
module pool_relu_q #(
    parameter int IMG_W = 26,
    parameter int SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               frame_start_in,
    input  logic               line_start_in,
    input  logic               frame_end_in,
    input  logic signed [15:0] sig_layer_in,
    output logic               valid_out,
    output logic               frame_start_out,
    output logic               line_start_out,
    output logic               frame_end_out,
    output logic [7:0]         pool_out
);
    localparam int CW   = $clog2(IMG_W + 1);
    localparam int LB_N = IMG_W / 2;
    localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [6:0]    h_q, h_d;
    logic [6:0]    linebuf [LB_N];

    logic          valid_out_q, valid_out_d;
    logic          frame_start_out_q, frame_start_out_d;
    logic          line_start_out_q, line_start_out_d;
    logic          frame_end_out_q, frame_end_out_d;
    logic [6:0]    pool_q, pool_d;

    logic          accept;
    logic [CW-1:0] cur_col;
    logic [15:0]   cur_row;
    logic [15:0]   shifted;
    logic [6:0]    q, hm, lb_rd;
    logic [LBW-1:0] lb_idx;
    logic          lb_we;

    always_comb begin
        shifted = '0;
        q       = '0;
        if (!sig_layer_in[15]) begin
            shifted = sig_layer_in >>> SHIFT;
            q       = (shifted > 16'd127) ? 7'd127 : shifted[6:0];
        end
    end

    // Column/row of the pixel currently on the input, before counters update.
    assign cur_col = (frame_start_in || line_start_in) ? '0 : col_q;
    assign cur_row = frame_start_in ? 16'd0 : (line_start_in ? 16'(row_q + 16'd1) : row_q);
    assign accept  = valid_in && (state_q == ACTIVE || frame_start_in);
    assign hm      = (q > h_q) ? q : h_q;
    assign lb_idx  = LBW'(cur_col >> 1);
    assign lb_rd   = linebuf[lb_idx];

    always_comb begin
        state_d           = state_q;
        row_d             = row_q;
        col_d             = col_q;
        h_d               = h_q;
        lb_we             = 1'b0;
        valid_out_d       = 1'b0;
        frame_start_out_d = 1'b0;
        line_start_out_d  = 1'b0;
        frame_end_out_d   = 1'b0;
        pool_d            = '0;
        if (accept) begin
            state_d         = frame_end_in ? IDLE : ACTIVE;
            row_d           = cur_row;
            col_d           = (cur_col == CW'(IMG_W)) ? cur_col : cur_col + CW'(1);
            frame_end_out_d = frame_end_in;
            if (cur_col < CW'(IMG_W)) begin
                if (!cur_col[0]) begin
                    h_d = q;
                end else if (!cur_row[0]) begin
                    lb_we = 1'b1;
                end else begin
                    valid_out_d       = 1'b1;
                    pool_d            = (lb_rd > hm) ? lb_rd : hm;
                    line_start_out_d  = (cur_col == CW'(1));
                    frame_start_out_d = (cur_col == CW'(1)) && (cur_row == 16'd1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            row_q             <= '0;
            col_q             <= '0;
            h_q               <= '0;
            valid_out_q       <= 1'b0;
            frame_start_out_q <= 1'b0;
            line_start_out_q  <= 1'b0;
            frame_end_out_q   <= 1'b0;
            pool_q            <= '0;
        end else begin
            state_q           <= state_d;
            row_q             <= row_d;
            col_q             <= col_d;
            h_q               <= h_d;
            valid_out_q       <= valid_out_d;
            frame_start_out_q <= frame_start_out_d;
            line_start_out_q  <= line_start_out_d;
            frame_end_out_q   <= frame_end_out_d;
            pool_q            <= pool_d;
        end
    end

    // Contents only matter after an even row has rewritten them, so no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= hm;
        end
    end

    assign valid_out       = valid_out_q;
    assign frame_start_out = frame_start_out_q;
    assign line_start_out  = line_start_out_q;
    assign frame_end_out   = frame_end_out_q;
    assign pool_out        = {1'b0, pool_q};
endmodule

// File: tb/tb_pool_relu_q.sv
// Bench for pool_relu_q: two instances (IMG_W=4 and IMG_W=5) share one input stream and are
// compared every cycle against a frame-level 2x2 max-pool model.
module tb_pool_relu_q;
    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in, fs_in, ls_in, fe_in;
    logic signed [15:0] x_in;
    logic              vo [2];
    logic              fso [2];
    logic              lso [2];
    logic              feo [2];
    logic [7:0]        po [2];

    int checks   = 0;
    int failures = 0;

    bit m_act [2];
    int m_row [2];
    int m_col [2];
    int rowq  [2][2][32];
    bit e_vld [2];
    bit e_fs  [2];
    bit e_ls  [2];
    bit e_fe  [2];
    int e_val [2];

    int got    [2][$];
    int ls_cnt [2];
    int fs_cnt [2];
    int fe_cnt [2];
    int pix[$];
    bit gaps;

    always #5 clk = ~clk;

    pool_relu_q #(.IMG_W(4), .SHIFT(4)) u0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .frame_start_in(fs_in),
        .line_start_in(ls_in), .frame_end_in(fe_in), .sig_layer_in(x_in),
        .valid_out(vo[0]), .frame_start_out(fso[0]), .line_start_out(lso[0]),
        .frame_end_out(feo[0]), .pool_out(po[0])
    );

    pool_relu_q #(.IMG_W(5), .SHIFT(4)) u1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .frame_start_in(fs_in),
        .line_start_in(ls_in), .frame_end_in(fe_in), .sig_layer_in(x_in),
        .valid_out(vo[1]), .frame_start_out(fso[1]), .line_start_out(lso[1]),
        .frame_end_out(feo[1]), .pool_out(po[1])
    );

    function automatic int quant(int x);
        if (x < 0) return 0;
        return (x / 16 > 127) ? 127 : x / 16;
    endfunction

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic void model_idle(int k);
        e_vld[k] = 0; e_fs[k] = 0; e_ls[k] = 0; e_fe[k] = 0; e_val[k] = 0;
    endfunction

    function automatic void model_reset(int k);
        model_idle(k);
        m_act[k] = 0; m_row[k] = 0; m_col[k] = 0;
    endfunction

    function automatic void model_px(int k, bit fs, bit ls, bit fe, int x);
        int w;
        w = (k == 0) ? 4 : 5;
        model_idle(k);
        if (!m_act[k] && !fs) return;
        if (fs) begin
            m_act[k] = 1; m_row[k] = 0; m_col[k] = 0;
            foreach (rowq[k][r, c]) rowq[k][r][c] = 0;
        end else if (ls) begin
            m_row[k]++; m_col[k] = 0;
        end else begin
            m_col[k]++;
        end
        if (m_col[k] < w) begin
            int r, c;
            r = m_row[k] % 2;
            c = m_col[k];
            rowq[k][r][c] = quant(x);
            if (r == 1 && c % 2 == 1) begin
                e_vld[k] = 1;
                e_val[k] = max4(rowq[k][0][c-1], rowq[k][0][c], rowq[k][1][c-1], rowq[k][1][c]);
                e_ls[k]  = (c == 1);
                e_fs[k]  = (c == 1) && (m_row[k] == 1);
            end
        end
        if (fe) begin
            m_act[k] = 0;
            e_fe[k]  = 1;
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_u%0d_valid", tag, k), 16'(vo[k]), 16'(e_vld[k]));
            check($sformatf("%s_u%0d_fs", tag, k), 16'(fso[k]), 16'(e_fs[k]));
            check($sformatf("%s_u%0d_ls", tag, k), 16'(lso[k]), 16'(e_ls[k]));
            check($sformatf("%s_u%0d_fe", tag, k), 16'(feo[k]), 16'(e_fe[k]));
            if (e_vld[k]) check($sformatf("%s_u%0d_pool", tag, k), 16'(po[k]), 16'(e_val[k]));
            if (vo[k] === 1'b1) begin
                got[k].push_back(int'(po[k]));
                if (lso[k] === 1'b1) ls_cnt[k]++;
                if (fso[k] === 1'b1) fs_cnt[k]++;
            end
            if (feo[k] === 1'b1) fe_cnt[k]++;
        end
    endtask

    task automatic cyc(input bit v, input bit fs, input bit ls, input bit fe, input int x, input string tag);
        valid_in = v; fs_in = fs; ls_in = ls; fe_in = fe; x_in = 16'(x);
        for (int k = 0; k < 2; k++) begin
            if (v) model_px(k, fs, ls, fe, x);
            else   model_idle(k);
        end
        @(posedge clk);
        #1;
        cmp_all(tag);
    endtask

    task automatic send_frame(input int w, input int h, input int npix, input string tag);
        for (int i = 0; i < npix; i++) begin
            int c, x;
            c = i % w;
            x = (pix.size() > 0) ? pix.pop_front() : int'($urandom_range(0, 6000)) - 1500;
            if (gaps && $urandom_range(0, 2) == 0) cyc(0, 0, 0, 0, 0, tag);
            cyc(1, i == 0, c == 0, i == w * h - 1, x, tag);
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            got[k].delete();
            ls_cnt[k] = 0; fs_cnt[k] = 0; fe_cnt[k] = 0;
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 0; fs_in = 0; ls_in = 0; fe_in = 0; x_in = '0; gaps = 0;
        model_reset(0); model_reset(1);
        repeat (3) @(posedge clk);
        #1;
        cmp_all("reset");
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, "idle");

        // Worked example: 4 wide, 2 rows.
        clear_stats();
        pix = '{16, 32, -5, 48, 64, 0, 160, 4000};
        send_frame(4, 2, 8, "t1");
        cyc(0, 0, 0, 0, 0, "t1_tail");
        check("t1_count", 16'(got[0].size()), 16'd2);
        check("t1_out0", 16'(got[0].size() > 0 ? got[0][0] : -1), 16'd4);
        check("t1_out1", 16'(got[0].size() > 1 ? got[0][1] : -1), 16'd127);

        // Same frame with random input gaps.
        clear_stats();
        gaps = 1;
        pix = '{16, 32, -5, 48, 64, 0, 160, 4000};
        send_frame(4, 2, 8, "t2");
        cyc(0, 0, 0, 0, 0, "t2_tail");
        check("t2_count", 16'(got[0].size()), 16'd2);
        check("t2_out0", 16'(got[0].size() > 0 ? got[0][0] : -1), 16'd4);
        check("t2_out1", 16'(got[0].size() > 1 ? got[0][1] : -1), 16'd127);
        gaps = 0;

        // All-negative 4x4.
        clear_stats();
        for (int i = 0; i < 16; i++) pix.push_back(-int'($urandom_range(1, 30000)));
        send_frame(4, 4, 16, "t3");
        check("t3_count", 16'(got[0].size()), 16'd4);
        check("t3_sum", 16'(got[0].sum()), 16'd0);
        check("t3_ls_cnt", 16'(ls_cnt[0]), 16'd2);

        // Odd width and odd row count on the 5-wide instance.
        clear_stats();
        for (int i = 0; i < 15; i++) pix.push_back(160);
        send_frame(5, 3, 15, "t4");
        check("t4_fe_pulse", 16'(feo[1]), 16'd1);
        check("t4_fe_alone", 16'(vo[1]), 16'd0);
        check("t4_count", 16'(got[1].size()), 16'd2);
        check("t4_out0", 16'(got[1].size() > 0 ? got[1][0] : -1), 16'd10);
        check("t4_out1", 16'(got[1].size() > 1 ? got[1][1] : -1), 16'd10);

        // Stray pixels before any start, then a restart in row 1.
        clear_stats();
        for (int i = 0; i < 4; i++) cyc(1, 0, i == 0, 0, 3000, "t5_stray");
        check("t5_no_out", 16'(got[0].size() + got[1].size()), 16'd0);
        send_frame(4, 4, 6, "t5_abort");
        gaps = 1;
        send_frame(4, 4, 16, "t5_restart");
        gaps = 0;
        cyc(0, 0, 0, 0, 0, "t5_tail");
        check("t5_fs_cnt", 16'(fs_cnt[0]), 16'd2);
        check("t5_fe_cnt", 16'(fe_cnt[0]), 16'd1);

        // One-pixel frame.
        clear_stats();
        cyc(1, 1, 1, 1, 500, "t6");
        cyc(0, 0, 0, 0, 0, "t6_tail");
        check("t6_fe_cnt", 16'(fe_cnt[0]), 16'd1);
        check("t6_no_out", 16'(got[0].size()), 16'd0);

        // Reset while an output is being presented in row 1.
        clear_stats();
        send_frame(4, 4, 6, "t7a");
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t7_rst_u%0d_valid", k), 16'(vo[k]), 16'd0);
            check($sformatf("t7_rst_u%0d_fs", k), 16'(fso[k]), 16'd0);
            check($sformatf("t7_rst_u%0d_ls", k), 16'(lso[k]), 16'd0);
            check($sformatf("t7_rst_u%0d_fe", k), 16'(feo[k]), 16'd0);
            check($sformatf("t7_rst_u%0d_pool", k), 16'(po[k]), 16'd0);
            model_reset(k);
        end
        cyc(0, 0, 0, 0, 0, "t7_hold");
        rst = 1'b0;
        cyc(1, 0, 1, 0, 2000, "t7_stray");
        send_frame(4, 4, 16, "t7b");

        // Random frames with gaps at both widths.
        gaps = 1;
        for (int f = 0; f < 8; f++) begin
            if (f % 2 == 0) send_frame(4, 4, 16, "rnd4");
            else            send_frame(5, 3, 15, "rnd5");
            cyc(0, 0, 0, 0, 0, "rnd_tail");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pool_relu_q.md
# pool_relu_q

Post-convolution stage directly downstream of the conv engine. Consumes the conv engine's streamed signed 16-bit layer output (`sig_layer` plus valid/frame/line markers), applies ReLU, requantizes to 8 bits with saturation, and performs 2x2 stride-2 max pooling using a one-row buffer. It emits a pooled int8 stream with its own frame/line markers for the next layer or writeback.

## Interface
Parameters:
- `IMG_W`, 26: input row width in pixels (conv output width); ≥2.
- `SHIFT`, 4: requantization arithmetic right shift.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `valid_in`  in  1  `sig_layer_in` and markers valid this cycle.
- `frame_start_in`  in  1  pixel is row 0, col 0 of a frame (implies line start).
- `line_start_in`  in  1  pixel is col 0 of a row.
- `frame_end_in`  in  1  pixel is last of frame.
- `sig_layer_in`  in  16  signed conv result.
- `valid_out`  out  1  `pool_out` valid.
- `frame_start_out`  out  1  first pooled pixel of frame.
- `line_start_out`  out  1  first pooled pixel of an output row.
- `frame_end_out`  out  1  end-of-frame pulse.
- `pool_out`  out  8  signed pooled value, range 0..127.

## Operation
- Markers are sampled only when `valid_in`=1. No backpressure; one pixel per cycle accepted.
- States: IDLE, ACTIVE.
  - IDLE: all pixels are ignored until `frame_start_in`. Then enter ACTIVE with row=0, col=0.
  - ACTIVE: process pixels. On an accepted `frame_end_in`, return to IDLE.
  - `frame_start_in` in ACTIVE aborts the current frame and restarts at row 0, col 0. No frame_end_out is emitted for the aborted frame.
- Counters: `col` is set to 0 on `line_start_in`, otherwise increments per accepted pixel. `row` increments on every `line_start_in` that is not a frame start.
- Quantize every pixel: q = min(max(x,0) >>> SHIFT, 127). This is a 7-bit magnitude, output zero-extended to 8 bits.
- Horizontal pairing:
  - At even col, hold q in register `h`.
  - At odd col, form `hm = max(h, q)`.
- Vertical pairing, using `linebuf` with IMG_W/2 entries of 7 bits indexed by col>>1:
  - Even row, odd col: write `hm` to `linebuf`.
  - Odd row, odd col: output `max(linebuf, hm)`.
- Boundary cases:
  - Odd IMG_W: the last column is dropped.
  - Odd row count: the last row is dropped, since even rows emit nothing.
  - col ≥ IMG_W (extra pixels): ignored, no buffer write, no output.
- Marker generation:
  - `line_start_out`=1 on the output produced at col 1 of each odd row.
  - `frame_start_out`=1 on the output at row 1, col 1.
  - `frame_end_out`=1 one cycle after `frame_end_in` is accepted. It coincides with `valid_out` if that pixel produced an output; otherwise it is a standalone pulse with `valid_out`=0.

## Timing
- Reset values: all outputs 0, state IDLE, `row`/`col`/`h` cleared. `linebuf` contents are don't-care and need no reset.
- Latency: exactly 1 cycle from accepting the odd-row/odd-col pixel to `valid_out`, all outputs registered.
- Output markers are single-cycle pulses aligned with their `valid_out`.
- Gaps in `valid_in` stall the counters. The output rate follows the input: at most 1 output per 4 input pixels on average, and 1 per 2 within an odd row.
- `rst` asserted mid-frame: outputs drop to 0 asynchronously, and the block waits in IDLE for the next `frame_start_in`.
- `frame_start_in` and `frame_end_in` on the same pixel (1-pixel frame): the block enters and exits ACTIVE on that pixel, with no output and `frame_end_out` pulsing once.

## Test plan
- IMG_W=4, SHIFT=4, 2 rows: row0 = 16, 32, −5, 48; row1 = 64, 0, 160, 4000 → outputs 4 (`frame_start_out`=1, `line_start_out`=1) then 127 (`frame_end_out`=1). Each output appears 1 cycle after its pixel.
- All-negative 4×4 frame → four outputs, all 0. Each odd row's first output has `line_start_out`=1.
- IMG_W=5, 3 rows of the value 160 → outputs 10, 10 only. Col 4 and row 2 are dropped. `frame_end_out` is a standalone pulse 1 cycle after the last pixel.
- Random `valid_in` gaps in the first test → identical outputs, with each still 1 cycle after its completing pixel.
- Pixels before any `frame_start_in`, and a `frame_start_in` mid-row 1 of a frame → no output before the start. The restarted frame's first output carries `frame_start_out`, and no stale `linebuf` data appears.
- `rst` pulsed during row 1 → outputs 0 immediately. A following full frame pools correctly.
